// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for a five-stage in-order pipeline. It decides
// each cycle whether the pipeline advances, freezes on an outstanding memory
// response, inserts a load-use bubble, or flushes after a taken branch. It
// also keeps saturating counts of frozen cycles and inserted bubbles.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low (0 = reset)
//   id_rs1/rs2   source register indices of the instruction in ID
//   id_uses_rs1/rs2  ID instruction reads that source
//   ex_rd        destination register of the instruction in EX
//   ex_mem_read  EX instruction is a load
//   ex_br_taken  EX resolved a taken branch/jump
//   imem_resp    instruction-memory response valid
//   dmem_req     MEM instruction has a data access outstanding
//   dmem_resp    data-memory response valid
//   pc_load .. mem_wb_load  stage-register load enables
//   id_ex_bubble zero the ID/EX control word on load
//   if_id_flush  IF/ID loads a NOP
//   stall_cnt    saturating count of frozen cycles
//   bubble_cnt   saturating count of inserted ID/EX bubbles
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  logic imem_done_q;
  logic dmem_done_q;
  logic imem_ok;
  logic dmem_ok;
  logic advance;
  logic load_use;

  // A response that arrives while the other side is still pending is
  // remembered in a done flag so the pipeline can advance later without
  // the memory having to hold its response valid.
  assign imem_ok = imem_resp | imem_done_q;
  assign dmem_ok = !dmem_req | dmem_resp | dmem_done_q;
  assign advance = imem_ok & dmem_ok;

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    id_ex_load   = 1'b0;
    ex_mem_load  = 1'b0;
    mem_wb_load  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (rst && advance) begin
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
      id_ex_load  = 1'b1;
      if (ex_br_taken) begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        // The bubble moves the load past EX, so load_use drops next cycle
        // and the stall lasts exactly one advancing cycle.
        id_ex_bubble = 1'b1;
      end else begin
        pc_load    = 1'b1;
        if_id_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else if (advance) begin
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      if (imem_resp) imem_done_q <= 1'b1;
      if (dmem_req && dmem_resp) dmem_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (!advance) stall_cnt <= sat_inc(stall_cnt);
      if (advance && id_ex_bubble) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_mem_read, ex_br_taken;
  logic        imem_resp, dmem_req, dmem_resp;

  logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic        id_ex_bubble, if_id_flush;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        pc_load4, if_id_load4, id_ex_load4, ex_mem_load4, mem_wb_load4;
  logic        id_ex_bubble4, if_id_flush4;
  logic [3:0]  stall_cnt4, bubble_cnt4;

  int checks;
  int failures;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_load(pc_load4), .if_id_load(if_id_load4), .id_ex_load(id_ex_load4),
    .ex_mem_load(ex_mem_load4), .mem_wb_load(mem_wb_load4),
    .id_ex_bubble(id_ex_bubble4), .if_id_flush(if_id_flush4),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       imem;
    logic       dreq;
    logic       dresp;
    logic       br;
    logic       mrd;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [6:0] exp; // {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush}
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
            id_ex_bubble, if_id_flush};
  endfunction

  task automatic idle();
    rst = 1'b1;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_br_taken = 1'b0;
    imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; imem_resp = v.imem; dmem_req = v.dreq; dmem_resp = v.dresp;
    ex_br_taken = v.br; ex_mem_read = v.mrd; ex_rd = v.rd;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();

    //          name          rst imem dreq dresp br mrd rd  rs1 rs2 u1 u2 exp
    vecs[0]  = '{"normal",    1, 1, 0, 0, 0, 0, 5'd0, 5'd3, 5'd4, 1, 1, 7'b1111100};
    vecs[1]  = '{"lu_rs1",    1, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0, 7'b0011110};
    vecs[2]  = '{"lu_x0",     1, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 7'b1111100};
    vecs[3]  = '{"lu_rs2",    1, 1, 0, 0, 0, 1, 5'd9, 5'd2, 5'd9, 0, 1, 7'b0011110};
    vecs[4]  = '{"lu_unused", 1, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd5, 0, 0, 7'b1111100};
    vecs[5]  = '{"no_load",   1, 1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd1, 1, 0, 7'b1111100};
    vecs[6]  = '{"br_lu",     1, 1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd1, 1, 0, 7'b1111111};
    vecs[7]  = '{"imem_wait", 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0000000};
    vecs[8]  = '{"dmem_wait", 1, 1, 1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 7'b0000000};
    vecs[9]  = '{"both_resp", 1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b1111100};
    vecs[10] = '{"rst_norm",  0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0000000};
    vecs[11] = '{"rst_br",    0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 7'b0000000};

    do_reset();
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check("reset_imem_flag", 32'(dut.imem_done_q), 32'd0);
    check("reset_dmem_flag", 32'(dut.dmem_done_q), 32'd0);

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      #1;
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      idle();
      do_reset();
    end

    // Normal flow: counters stay at zero.
    imem_resp = 1'b1;
    repeat (3) step();
    check("normal_stall_cnt", 32'(stall_cnt), 32'd0);
    check("normal_bubble_cnt", 32'(bubble_cnt), 32'd0);

    // One load-use edge adds one bubble; the next cycle is normal again.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    step();
    check("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    check("lu_after_outs", 32'(outs()), 32'b1111100);

    // Branch overriding a load-use hazard also counts a bubble.
    ex_br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    step();
    check("br_bubble_cnt", 32'(bubble_cnt), 32'd2);
    idle();
    do_reset();

    // Split responses: dmem_resp in cycle 2, imem_resp in cycle 5.
    for (int c = 0; c < 6; c++) begin
      dmem_req  = 1'b1;
      dmem_resp = (c == 2);
      imem_resp = (c == 5);
      #1;
      check($sformatf("split_exmem_c%0d", c), 32'(ex_mem_load), (c == 5) ? 32'd1 : 32'd0);
      check($sformatf("split_pc_c%0d", c), 32'(pc_load), (c == 5) ? 32'd1 : 32'd0);
      check($sformatf("split_dflag_c%0d", c), 32'(dut.dmem_done_q),
            (c >= 3) ? 32'd1 : 32'd0);
      step();
    end
    check("split_stall_cnt", 32'(stall_cnt), 32'd5);
    check("split_dflag_clear", 32'(dut.dmem_done_q), 32'd0);
    idle();
    do_reset();

    // Latched imem response lets a later dmem response advance; a repeated
    // imem response while the flag is set changes nothing.
    dmem_req = 1'b1; imem_resp = 1'b1;
    step();
    check("imem_flag_set", 32'(dut.imem_done_q), 32'd1);
    step();
    check("imem_flag_dup", 32'(dut.imem_done_q), 32'd1);
    imem_resp = 1'b0; dmem_resp = 1'b1;
    #1;
    check("imem_flag_adv", 32'(outs()), 32'b1111100);
    step();
    check("imem_flag_clear", 32'(dut.imem_done_q), 32'd0);
    check("imem_flag_stall", 32'(stall_cnt), 32'd2);

    // Reset mid-stall discards the latched imem response.
    dmem_resp = 1'b0; imem_resp = 1'b1;
    step();
    check("mid_imem_flag", 32'(dut.imem_done_q), 32'd1);
    imem_resp = 1'b0;
    do_reset();
    dmem_resp = 1'b1;
    #1;
    check("mid_rst_no_adv", 32'(outs()), 32'b0000000);
    idle();
    do_reset();

    // Saturation with the narrow counter, then reset.
    imem_resp = 1'b0;
    repeat (20) step();
    check("sat_stall_cnt4", 32'(stall_cnt4), 32'd15);
    check("sat_stall_cnt16", 32'(stall_cnt), 32'd20);
    check("sat_iflag", 32'(dut4.imem_done_q), 32'd0);
    imem_resp = 1'b1;
    rst = 1'b0;
    #1;
    check("sat_rst_outs", 32'({pc_load4, if_id_load4, id_ex_load4, ex_mem_load4,
                                mem_wb_load4, id_ex_bubble4, if_id_flush4}), 32'd0);
    step();
    check("sat_rst_stall", 32'(stall_cnt4), 32'd0);
    check("sat_rst_bubble", 32'(bubble_cnt4), 32'd0);
    check("sat_rst_flags", 32'({dut4.imem_done_q, dut4.dmem_done_q}), 32'd0);
    rst = 1'b1;
    #1;
    check("sat_post_rst", 32'(outs()), 32'b1111100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
